// File: rtl/toe_pkg.sv
// Shared types and helpers for the TOE receive-side arbiter.
package toe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int TOE_FRAME_CNT_W = 32;

    // LSB position of requester idx's beat inside a flattened beat bus.
    function automatic int beat_slice_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/toe_rr_pick.sv
// Combinational rotate-priority picker: first set request at or above rr_ptr_i, with wrap.
module toe_rr_pick #(
    parameter int P_NUM_REQ = 4,
    parameter int P_IDX_W   = $clog2(P_NUM_REQ)
) (
    input  logic [P_NUM_REQ-1:0] req_i,
    input  logic [P_IDX_W-1:0]   rr_ptr_i,
    output logic                 any_o,
    output logic [P_IDX_W-1:0]   idx_o
);

    // Scan from the farthest offset down so the nearest hit is assigned last.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        for (int i = P_NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[(int'(rr_ptr_i) + i) % P_NUM_REQ]) begin
                any_o = 1'b1;
                idx_o = P_IDX_W'((int'(rr_ptr_i) + i) % P_NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/toe_rx_arb.sv
// Frame-locked round-robin arbiter feeding the TOE ingress datapath from FWFT queues.
// Optional per-requester frame counters on o_frame_cnt when TOE_ARB_STATS_EN is defined.
module toe_rx_arb
    import toe_pkg::*;
#(
    parameter int P_DATA_WIDTH = 64,
    parameter int P_NUM_REQ    = 4,
    parameter int P_IDX_W      = $clog2(P_NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [P_NUM_REQ-1:0]              i_valid,
    input  logic [P_NUM_REQ-1:0]              i_last,
    input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_data,
    output logic [P_NUM_REQ-1:0]              i_read,
    input  logic                              i_ready,
    output logic [P_DATA_WIDTH-1:0]           o_data,
    output logic                              o_en,
    output logic                              o_last,
    output logic [P_IDX_W-1:0]                o_gnt_id,
    output logic                              o_busy
`ifdef TOE_ARB_STATS_EN
    ,
    output logic [P_NUM_REQ*TOE_FRAME_CNT_W-1:0] o_frame_cnt
`endif
);

    arb_state_e                state_q;
    logic [P_IDX_W-1:0]        gnt_q;
    logic [P_IDX_W-1:0]        rr_ptr_q;
    logic [P_IDX_W-1:0]        rr_ptr_d;
    logic [P_DATA_WIDTH-1:0]   data_q;
    logic                      en_q;
    logic                      last_q;

    logic                      pick_any;
    logic [P_IDX_W-1:0]        pick_idx;
    logic                      xfer;
    logic                      xfer_last;
    int                        head_lsb;
    logic [P_DATA_WIDTH-1:0]   head_data;

    toe_rr_pick #(
        .P_NUM_REQ (P_NUM_REQ),
        .P_IDX_W   (P_IDX_W)
    ) u_pick (
        .req_i    (i_valid),
        .rr_ptr_i (rr_ptr_q),
        .any_o    (pick_any),
        .idx_o    (pick_idx)
    );

    // Pop is purely a function of registered grant plus live valid/ready.
    assign xfer      = (state_q == BUSY) & i_valid[gnt_q] & i_ready;
    assign xfer_last = xfer & i_last[gnt_q];
    assign rr_ptr_d  = (gnt_q == P_IDX_W'(P_NUM_REQ - 1)) ? '0 : gnt_q + P_IDX_W'(1);

    always_comb begin
        head_lsb  = beat_slice_lsb(int'(gnt_q), P_DATA_WIDTH);
        head_data = i_data[head_lsb +: P_DATA_WIDTH];
    end

    always_comb begin
        i_read        = '0;
        i_read[gnt_q] = xfer;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            data_q   <= '0;
            en_q     <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            en_q   <= xfer;
            last_q <= xfer_last;
            if (xfer) data_q <= head_data;
            case (state_q)
                IDLE: if (pick_any) begin
                    gnt_q   <= pick_idx;
                    state_q <= BUSY;
                end
                BUSY: if (xfer_last) begin
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_data   = data_q;
    assign o_en     = en_q;
    assign o_last   = last_q;
    assign o_gnt_id = gnt_q;
    assign o_busy   = (state_q == BUSY);

`ifdef TOE_ARB_STATS_EN
    logic [P_NUM_REQ-1:0][TOE_FRAME_CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (xfer_last) begin
            frame_cnt_q[gnt_q] <= frame_cnt_q[gnt_q] + TOE_FRAME_CNT_W'(1);
        end
    end

    assign o_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_toe_rx_arb.sv
// Directed bench for toe_rx_arb: FWFT queue model per requester, hand-computed expectations.
module tb_toe_rx_arb;

    localparam int W = 64;
    localparam int N = 4;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     i_valid;
    logic [N-1:0]     i_last;
    logic [N*W-1:0]   i_data;
    logic [N-1:0]     i_read;
    logic             i_ready;
    logic [W-1:0]     o_data;
    logic             o_en;
    logic             o_last;
    logic [1:0]       o_gnt_id;
    logic             o_busy;
`ifdef TOE_ARB_STATS_EN
    logic [N*32-1:0]  o_frame_cnt;
`endif

    toe_rx_arb #(
        .P_DATA_WIDTH (W),
        .P_NUM_REQ    (N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .i_last   (i_last),
        .i_data   (i_data),
        .i_read   (i_read),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_en     (o_en),
        .o_last   (o_last),
        .o_gnt_id (o_gnt_id),
        .o_busy   (o_busy)
`ifdef TOE_ARB_STATS_EN
        ,
        .o_frame_cnt (o_frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_chk;
    int           n_bad;
    logic [W:0]   mem [N][16];
    int           hd [N];
    int           tl [N];
    logic [N-1:0] hold;

    logic [N-1:0] s_rd;
    logic         s_en;
    logic         s_last;
    logic         s_busy;
    logic [W-1:0] s_data;
    logic [1:0]   s_gnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            i_valid[k]        = (hd[k] != tl[k]) && !hold[k];
            i_last[k]         = (hd[k] != tl[k]) ? mem[k][hd[k]][W] : 1'b0;
            i_data[k*W +: W]  = (hd[k] != tl[k]) ? mem[k][hd[k]][W-1:0] : '0;
        end
    endtask

    task automatic push(input int k, input logic [W-1:0] d, input logic lst);
        mem[k][tl[k]] = {lst, d};
        tl[k]++;
    endtask

    // Sample one cycle mid-period, then advance past the edge and pop whatever was read.
    task automatic tick();
        @(negedge clk);
        s_rd   = i_read;
        s_en   = o_en;
        s_last = o_last;
        s_busy = o_busy;
        s_data = o_data;
        s_gnt  = o_gnt_id;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) if (s_rd[k]) hd[k]++;
        drive();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        hold    = '0;
        i_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            hd[k] = 0;
            tl[k] = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [3:0]   e1_rd [6] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
    logic         e1_en [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [63:0]  e1_dt [6] = '{64'h0, 64'h0, 64'hA0, 64'hA1, 64'hA2, 64'hA2};
    logic [3:0]   e2_rd [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    logic [63:0]  bp_dt [4];
    int           bp_n;

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst_n   = 1'b0;
        i_ready = 1'b1;
        hold    = '0;
        for (int k = 0; k < N; k++) begin
            hd[k] = 0;
            tl[k] = 0;
        end
        drive();
        @(posedge clk);
        #1;
        chk("rst_read", i_read, 0);
        chk("rst_en", o_en, 0);
        chk("rst_data", o_data, 0);
        chk("rst_last", o_last, 0);
        chk("rst_gnt", o_gnt_id, 0);
        chk("rst_busy", o_busy, 0);

        // All four requesters hold single-beat frames from reset.
        do_reset();
        for (int k = 0; k < N; k++) begin
            push(k, 64'h10 + 64'(k), 1'b1);
            push(k, 64'h20 + 64'(k), 1'b1);
        end
        drive();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("rr_read_c%0d", i), s_rd, e2_rd[i]);
            if (i == 2) chk("rr_data_c2", s_data, 64'h10);
            if (i == 7) chk("rr_gnt_c7", s_gnt, 3);
            if (i == 9) chk("rr_gnt_c9", s_gnt, 0);
        end

        // Single requester, 3-beat frame.
        do_reset();
        push(2, 64'hA0, 1'b0);
        push(2, 64'hA1, 1'b0);
        push(2, 64'hA2, 1'b1);
        drive();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("one_read_c%0d", i), s_rd, e1_rd[i]);
            chk($sformatf("one_en_c%0d", i), s_en, e1_en[i]);
            if (i >= 2) chk($sformatf("one_data_c%0d", i), s_data, e1_dt[i]);
            if (i == 3) chk("one_last_c3", s_last, 0);
            if (i == 4) chk("one_last_c4", s_last, 1);
            if (i == 4) chk("one_gnt_c4", s_gnt, 2);
        end

        // Frame lock: req 1 stalls mid-frame while 0 and 3 wait.
        do_reset();
        push(1, 64'hB0, 1'b0);
        push(1, 64'hB1, 1'b0);
        push(1, 64'hB2, 1'b0);
        push(1, 64'hB3, 1'b1);
        drive();
        tick();
        chk("lock_read_c0", s_rd, 0);
        push(0, 64'h50, 1'b1);
        push(3, 64'h53, 1'b1);
        drive();
        tick();
        chk("lock_read_c1", s_rd, 4'h2);
        tick();
        chk("lock_read_c2", s_rd, 4'h2);
        hold[1] = 1'b1;
        drive();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("lock_read_s%0d", i), s_rd, 0);
            chk($sformatf("lock_busy_s%0d", i), s_busy, 1);
            chk($sformatf("lock_gnt_s%0d", i), s_gnt, 1);
        end
        hold[1] = 1'b0;
        drive();
        tick();
        chk("lock_read_b2", s_rd, 4'h2);
        tick();
        chk("lock_read_b3", s_rd, 4'h2);
        tick();
        chk("lock_read_gap", s_rd, 0);
        chk("lock_last", s_last, 1);
        chk("lock_data", s_data, 64'hB3);
        tick();
        chk("lock_next_req3", s_rd, 4'h8);

        // Back-pressure: i_ready alternates through a 4-beat frame.
        do_reset();
        for (int j = 0; j < 4; j++) push(0, 64'hC0 + 64'(j), (j == 3));
        drive();
        bp_n = 0;
        for (int i = 0; i < 10; i++) begin
            i_ready = (i % 2) == 1;
            tick();
            chk($sformatf("bp_read_c%0d", i), s_rd, ((i % 2) == 1 && i <= 7) ? 4'h1 : 4'h0);
            if (s_en) begin
                if (bp_n < 4) bp_dt[bp_n] = s_data;
                bp_n++;
            end
        end
        chk("bp_beats", bp_n, 4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("bp_data%0d", j), (bp_n > j) ? bp_dt[j] : 64'hX, 64'hC0 + 64'(j));
        i_ready = 1'b1;

`ifdef TOE_ARB_STATS_EN
        do_reset();
        for (int j = 0; j < 5; j++) push(3, 64'h300 + 64'(j), 1'b1);
        for (int j = 0; j < 2; j++) push(0, 64'h100 + 64'(j), 1'b1);
        drive();
        repeat (16) tick();
        chk("cnt_req0", o_frame_cnt[0*32 +: 32], 2);
        chk("cnt_req1", o_frame_cnt[1*32 +: 32], 0);
        chk("cnt_req2", o_frame_cnt[2*32 +: 32], 0);
        chk("cnt_req3", o_frame_cnt[3*32 +: 32], 5);
`endif

        // Reset lands on beat 2 of a 4-beat frame from req 1.
        do_reset();
        for (int j = 0; j < 4; j++) push(1, 64'hD0 + 64'(j), (j == 3));
        drive();
        tick();
        tick();
        chk("mrst_read_b1", s_rd, 4'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_read", i_read, 0);
        chk("mrst_en", o_en, 0);
        chk("mrst_data", o_data, 0);
        chk("mrst_last", o_last, 0);
        chk("mrst_gnt", o_gnt_id, 0);
        chk("mrst_busy", o_busy, 0);
        push(0, 64'hE0, 1'b1);
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("mrst_idle_c0", s_rd, 0);
        tick();
        chk("mrst_req0_first", s_rd, 4'h1);
        tick();
        tick();
        chk("mrst_req1_next", s_rd, 4'h2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
